mul_accumulator: RTL
====================

Name: mul_accumulator

Overview:
- Sequential accumulator directly downstream of the team's 8x8 array multiplier (16-bit product output).
- Sums a programmed number of consecutive products into a wide accumulator, using a valid/ready handshake.
- Presents the final sum with a one-cycle done pulse, for dot-product / FIR-style datapaths in the CAD design.

Parameters:
- NUM_TERMS, 4, number of products summed per operation (legal range >= 1).
- ACC_W, 24, accumulator and result width in bits (legal range >= 16).
- CNT_W, 8, term counter width; NUM_TERMS must be <= 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- prod_in  input  16  unsigned product from the multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  block accepts a product this cycle.
- result  output  ACC_W  final sum; holds until the next operation completes.
- done  output  1  one-cycle pulse when result is updated.
- busy  output  1  high from the start acceptance through the DONE state.
- ovf  output  1  sticky overflow flag for the current/last operation.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. On rst, at the clock edge: state=IDLE, acc=0, cnt=0, result=0, done=0, busy=0, prod_ready=0, ovf=0.
- Reset mid-operation: the partial sum is discarded and result is cleared.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Handshake: a product is accepted on a rising edge where prod_valid && prod_ready. prod_valid may be held across cycles; each accepted cycle consumes one term.
- FSM states:
  - IDLE: prod_ready=0, busy=0. If start=1, next state is ACC, with acc<=0, cnt<=0, ovf<=0.
  - ACC: prod_ready=1, busy=1. On accept: acc <= acc + zero-extended prod_in, cnt <= cnt+1. If the accept occurs with cnt == NUM_TERMS-1, next state is DONE and result <= acc + prod_in on the same edge.
  - DONE: done=1, busy=1, prod_ready=0, for exactly one cycle; then IDLE.
- Latency: done rises on the cycle after the last handshake edge. Minimum operation length is NUM_TERMS+2 cycles from start to done.
- NUM_TERMS=1: the first accept goes straight to DONE.
- start asserted in ACC or DONE is ignored; it is not queued.
- start and prod_valid in the same IDLE cycle: only start is acted on; no product is accepted (prod_ready=0).
- Arithmetic: unsigned. Any carry out of bit ACC_W-1 sets ovf (sticky until the next start). The sum wraps modulo 2^ACC_W unless the optional feature is compiled in.
- prod_in is ignored whenever it is not accepted.

Optional Feature:
- Macro MUL_ACC_SAT_EN.
- Defined: on an add that overflows, acc clamps to all-ones (2^ACC_W-1) and stays clamped for the rest of the operation; ovf is set as usual.
- Undefined: modular wraparound; ovf is still set. Port list is identical in both builds.

Decomposition:
- Shared package/header mul_acc_pkg holds:
  - the state encoding constants (IDLE=2'd0, ACC=2'd1, DONE=2'd2);
  - the product width constant PROD_W=16;
  - default ACC_W and NUM_TERMS.
- One natural sub-module, acc_add_sat: ACC_W-wide adder with carry-out and the MUL_ACC_SAT_EN clamp, used by the acc and result updates.
- FSM and counter stay in the top module.

Test Plan:
- Reset then idle: prod_valid=1 with no start -> prod_ready=0, result=0, done=0, busy=0 for 10 cycles.
- NUM_TERMS=4, ACC_W=24; start, then four back-to-back products of 65025 (255*255) -> done pulses one cycle after the 4th accept, result=260100, ovf=0; busy drops the cycle after done.
- Same config with prod_valid gapped (products 1, 2, 3, 4, with 2 idle cycles between each) -> result=10; cnt advances only on handshakes.
- ACC_W=16, NUM_TERMS=2, products 65025 and 65025:
  - without the macro -> result=64514, ovf=1;
  - with MUL_ACC_SAT_EN -> result=65535, ovf=1.
- Sequence: start, accept 2 of 4 terms, assert rst for one cycle, start again, send 4 products of 100 -> result=400, no residue from the aborted run; start pulsed during ACC has no effect.
- NUM_TERMS=1: start then product 7 -> result=7, done one cycle after the accept; a second start in the DONE cycle is ignored, and a start in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// mul_acc_pkg: shared state encoding and default widths for mul_accumulator.
package mul_acc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
    localparam int PROD_W = 16;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_NUM_TERMS = 4;
endpackage

// File: rtl/acc_add_sat.sv
// acc_add_sat: accumulator + product adder with carry-out; clamps to all-ones on carry when MUL_ACC_SAT_EN is defined.
module acc_add_sat
    import mul_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W-1:0] raw;
    assign {carry, raw} = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
`ifdef MUL_ACC_SAT_EN
    assign sum = carry ? '1 : raw;
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/mul_accumulator.sv
// mul_accumulator: sums NUM_TERMS handshaken products into result with a done pulse; MUL_ACC_SAT_EN selects saturating adds.
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int NUM_TERMS = DEF_NUM_TERMS,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  result,
    output logic              done,
    output logic              busy,
    output logic              ovf
);
    state_t           state, next;
    logic [ACC_W-1:0] acc, sum;
    logic [CNT_W-1:0] cnt;
    logic             carry, accept, last;

    acc_add_sat #(.ACC_W(ACC_W)) u_add (.acc(acc), .prod(prod_in), .sum(sum), .carry(carry));

    assign accept     = state == ACC && prod_valid;
    assign last       = cnt == CNT_W'(NUM_TERMS - 1);
    assign prod_ready = state == ACC;
    assign busy       = state != IDLE;
    assign done       = state == DONE;

    always_comb begin
        next = IDLE;
        if (state == IDLE) next = start ? ACC : IDLE;
        else if (state == ACC) next = accept && last ? DONE : ACC;
    end

    // result is loaded from the same adder output that feeds acc on the final term
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && start) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
            if (accept) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                ovf <= ovf | carry;
                if (last) result <= sum;
            end
        end
    end
endmodule
